// File: rtl/regfile_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Package     : regfile_pkg
// Description : Shared state encoding and address-width helper for regfile_mp.
// Revision    : 1.0
//==============================================================================
package regfile_pkg;

   typedef enum logic [1:0] {
      RF_RESET = 2'd0,
      RF_INIT  = 2'd1,
      RF_RUN   = 2'd2
   } rf_state_e;

   function automatic int rf_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Interface   : regfile_mp_if
// Description : Read/write port bundle of the multi-port register file.
// Revision    : 1.0
//==============================================================================
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int DEPTH   = 32,
   parameter int N_READ  = 2,
   parameter int N_WRITE = 2
) ();
   localparam int AW = rf_addr_w(DEPTH);

   logic [N_READ*AW-1:0]               rd_addr;
   logic [N_READ*WIDTH-1:0]            rd_data;
   logic [N_WRITE-1:0]                 wr_enable;
   logic [N_WRITE*AW-1:0]              wr_addr;
   logic [N_WRITE*WIDTH-1:0]           wr_data;
   logic                               ready;
   logic [DEPTH-1:0][WIDTH-1:0]        debug_reg_out;

   modport master (
      output rd_addr, wr_enable, wr_addr, wr_data,
      input  rd_data, ready, debug_reg_out
   );

   modport slave (
      input  rd_addr, wr_enable, wr_addr, wr_data,
      output rd_data, ready, debug_reg_out
   );

endinterface
`default_nettype wire

// File: rtl/regfile_init_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : regfile_init_ctrl
// Description : Post-reset clear sweep sequencer; gates issue via ready.
// Revision    : 1.0
//==============================================================================
module regfile_init_ctrl
   import regfile_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = rf_addr_w(DEPTH)
) (
   input  wire logic          clk,
   input  wire logic          reset,
   output logic               init_we,
   output logic [AW-1:0]      init_addr,
   output logic               ready
);

   rf_state_e         state_q;
   logic [AW-1:0]     cnt_q;
   logic              we_q;
   logic              ready_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= RF_INIT;
         cnt_q   <= '0;
         we_q    <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            RF_INIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == AW'(DEPTH - 1)) begin
                  state_q <= RF_RUN;
                  we_q    <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            RF_RUN: begin
            end
            default: begin
               state_q <= RF_INIT;
               cnt_q   <= '0;
               we_q    <= 1'b1;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign init_we   = we_q;
   assign init_addr = cnt_q;
   assign ready     = ready_q;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file with clear sweep,
//               hardwired zero register and optional write-to-read bypass.
// Revision    : 1.0
//==============================================================================
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int               WIDTH       = 64,
   parameter int               DEPTH       = 32,
   parameter int               N_READ      = 2,
   parameter int               N_WRITE     = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               BYPASS      = 1,
   parameter int               ZERO_REG    = 1
) (
   input  wire logic    clk,
   input  wire logic    reset,
   regfile_mp_if.slave  bus
);

   localparam int AW = rf_addr_w(DEPTH);

   logic                        init_we;
   logic [AW-1:0]               init_addr;
   logic                        ready;
   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [DEPTH-1:0][WIDTH-1:0] mem_d;

   regfile_init_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_init_ctrl (
      .clk       (clk),
      .reset     (reset),
      .init_we   (init_we),
      .init_addr (init_addr),
      .ready     (ready)
   );

   // Higher-numbered write ports are applied last so they win address conflicts.
   always_comb begin
      mem_d = mem_q;
      if (reset) begin
         if (init_we) begin
            mem_d[init_addr] = RESET_VALUE;
         end else if (ready) begin
            for (int p = 0; p < N_WRITE; p++) begin
               if (bus.wr_enable[p]) begin
                  mem_d[bus.wr_addr[p*AW +: AW]] = bus.wr_data[p*WIDTH +: WIDTH];
               end
            end
         end
      end
      if (ZERO_REG != 0) begin
         mem_d[0] = '0;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   for (genvar k = 0; k < N_READ; k++) begin : g_rd
      logic [AW-1:0]    w_ra;
      logic [WIDTH-1:0] w_rd;

      assign w_ra = bus.rd_addr[k*AW +: AW];

      always_comb begin
         w_rd = mem_q[w_ra];
         if (init_we) begin
            w_rd = RESET_VALUE;
         end else if ((BYPASS != 0) && ready) begin
            for (int p = 0; p < N_WRITE; p++) begin
               if (bus.wr_enable[p] && (bus.wr_addr[p*AW +: AW] == w_ra)) begin
                  w_rd = bus.wr_data[p*WIDTH +: WIDTH];
               end
            end
         end
         if ((ZERO_REG != 0) && (w_ra == '0)) begin
            w_rd = '0;
         end
      end

      assign bus.rd_data[k*WIDTH +: WIDTH] = w_rd;
   end

   assign bus.ready         = ready;
   assign bus.debug_reg_out = mem_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_regfile_mp
// Description : Scoreboard bench for regfile_mp (bypass and no-bypass builds).
// Revision    : 1.0
//==============================================================================
module tb_regfile_mp;

   localparam int W  = 64;
   localparam int D  = 32;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int AW = 5;

   localparam int SRC_RD_B  = 0;
   localparam int SRC_RD_N  = 1;
   localparam int SRC_DBG_B = 2;
   localparam int SRC_DBG_N = 3;
   localparam int SRC_RDY_B = 4;
   localparam int SRC_RDY_N = 5;

   typedef struct packed {
      logic [3:0]  src;
      logic [7:0]  idx;
      logic [63:0] val;
   } exp_t;

   logic  clk = 1'b0;
   logic  reset;
   int    n_chk  = 0;
   int    n_pass = 0;
   exp_t  exp_q[$];
   string tag_q[$];

   always #5 clk = ~clk;

   regfile_mp_if #(.WIDTH(W), .DEPTH(D), .N_READ(NR), .N_WRITE(NW)) if_b ();
   regfile_mp_if #(.WIDTH(W), .DEPTH(D), .N_READ(NR), .N_WRITE(NW)) if_n ();

   assign if_n.rd_addr   = if_b.rd_addr;
   assign if_n.wr_enable = if_b.wr_enable;
   assign if_n.wr_addr   = if_b.wr_addr;
   assign if_n.wr_data   = if_b.wr_data;

   regfile_mp #(
      .WIDTH(W), .DEPTH(D), .N_READ(NR), .N_WRITE(NW),
      .RESET_VALUE(64'h0), .BYPASS(1), .ZERO_REG(1)
   ) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b)
   );

   regfile_mp #(
      .WIDTH(W), .DEPTH(D), .N_READ(NR), .N_WRITE(NW),
      .RESET_VALUE(64'h0), .BYPASS(0), .ZERO_REG(1)
   ) u_dut_n (
      .clk   (clk),
      .reset (reset),
      .bus   (if_n)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] observe(input int src, input int idx);
      case (src)
         SRC_RD_B:  return if_b.rd_data[idx*W +: W];
         SRC_RD_N:  return if_n.rd_data[idx*W +: W];
         SRC_DBG_B: return if_b.debug_reg_out[idx];
         SRC_DBG_N: return if_n.debug_reg_out[idx];
         SRC_RDY_B: return {63'd0, if_b.ready};
         default:   return {63'd0, if_n.ready};
      endcase
   endfunction

   task automatic expect_val(input string tag, input int src, input int idx, input logic [63:0] val);
      exp_t e;
      e.src = 4'(src);
      e.idx = 8'(idx);
      e.val = val;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Compare everything queued for this cycle, then move to just after the next edge.
   task automatic tick();
      exp_t  e;
      string t;
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_val(t, observe(int'(e.src), int'(e.idx)), e.val);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] we, input int a0, input int a1,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input int r0, input int r1);
      if_b.wr_enable = we;
      if_b.wr_addr   = {AW'(a1), AW'(a0)};
      if_b.wr_data   = {d1, d0};
      if_b.rd_addr   = {AW'(r1), AW'(r0)};
   endtask

   task automatic expect_all_zero(input string tag);
      for (int i = 0; i < D; i++) begin
         expect_val(tag, SRC_DBG_B, i, 64'h0);
         expect_val(tag, SRC_DBG_N, i, 64'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      drive(2'b00, 0, 0, 64'h0, 64'h0, 0, 3);
      @(posedge clk);
      #1;
      expect_val("rst_ready_b", SRC_RDY_B, 0, 64'h0);
      expect_val("rst_ready_n", SRC_RDY_N, 0, 64'h0);
      expect_val("rst_rd_r0",   SRC_RD_B,  0, 64'h0);
      expect_val("rst_rd_r3",   SRC_RD_B,  1, 64'h0);
      tick();
      reset = 1'b1;

      for (int k = 0; k < 34; k++) begin
         expect_val("sweep_ready_b", SRC_RDY_B, 0, (k >= D) ? 64'h1 : 64'h0);
         expect_val("sweep_ready_n", SRC_RDY_N, 0, (k >= D) ? 64'h1 : 64'h0);
         tick();
      end
      expect_all_zero("sweep_clear");
      tick();

      drive(2'b01, 1, 0, 64'hdeadbeef, 64'h0, 1, 1);
      expect_val("wr_bypass_rd",  SRC_RD_B,  0, 64'hdeadbeef);
      expect_val("wr_nobyp_old",  SRC_RD_N,  0, 64'h0);
      expect_val("wr_dbg_before", SRC_DBG_B, 1, 64'h0);
      tick();
      drive(2'b00, 1, 0, 64'h0, 64'h0, 1, 1);
      expect_val("wr_persist",    SRC_RD_B,  0, 64'hdeadbeef);
      expect_val("wr_nobyp_late", SRC_RD_N,  0, 64'hdeadbeef);
      expect_val("wr_dbg_b",      SRC_DBG_B, 1, 64'hdeadbeef);
      expect_val("wr_dbg_n",      SRC_DBG_N, 1, 64'hdeadbeef);
      tick();

      drive(2'b11, 21, 21, 64'h1111, 64'hcafebabe, 21, 0);
      expect_val("conf_bypass",   SRC_RD_B,  0, 64'hcafebabe);
      expect_val("conf_nobyp",    SRC_RD_N,  0, 64'h0);
      expect_val("conf_r0_read",  SRC_RD_B,  1, 64'h0);
      tick();
      drive(2'b00, 21, 21, 64'h0, 64'h0, 21, 21);
      expect_val("conf_rd_b",     SRC_RD_B,  0, 64'hcafebabe);
      expect_val("conf_rd_n",     SRC_RD_N,  1, 64'hcafebabe);
      expect_val("conf_dbg_b",    SRC_DBG_B, 21, 64'hcafebabe);
      expect_val("conf_dbg_n",    SRC_DBG_N, 21, 64'hcafebabe);
      tick();

      drive(2'b11, 5, 6, 64'haaaa, 64'hbbbb, 5, 6);
      expect_val("split_byp_p0",  SRC_RD_B,  0, 64'haaaa);
      expect_val("split_byp_p1",  SRC_RD_B,  1, 64'hbbbb);
      tick();
      drive(2'b00, 5, 6, 64'h0, 64'h0, 6, 5);
      expect_val("split_rd_p0",   SRC_RD_N,  0, 64'hbbbb);
      expect_val("split_rd_p1",   SRC_RD_N,  1, 64'haaaa);
      tick();

      drive(2'b01, 0, 0, 64'hffff, 64'h0, 0, 0);
      expect_val("zero_byp",      SRC_RD_B,  0, 64'h0);
      expect_val("zero_byp_p1",   SRC_RD_B,  1, 64'h0);
      expect_val("zero_nobyp",    SRC_RD_N,  0, 64'h0);
      tick();
      drive(2'b00, 0, 0, 64'h0, 64'h0, 0, 0);
      expect_val("zero_dbg_b",    SRC_DBG_B, 0, 64'h0);
      expect_val("zero_dbg_n",    SRC_DBG_N, 0, 64'h0);
      expect_val("zero_rd",       SRC_RD_B,  0, 64'h0);
      tick();

      drive(2'b00, 20, 20, 64'hffff, 64'hffff, 20, 0);
      expect_val("dis_byp",       SRC_RD_B,  0, 64'h0);
      expect_val("dis_nobyp",     SRC_RD_N,  0, 64'h0);
      tick();
      expect_val("dis_dbg",       SRC_DBG_B, 20, 64'h0);
      expect_val("dis_rd",        SRC_RD_B,  0, 64'h0);
      tick();

      // Partial sweep interrupted at cycle 10, with user writes presented throughout INIT.
      reset = 1'b0;
      drive(2'b00, 0, 0, 64'h0, 64'h0, 21, 1);
      tick();
      reset = 1'b1;
      expect_val("mid_rst_rd",    SRC_RD_B,  0, 64'h0);
      expect_val("mid_rst_dbg21", SRC_DBG_B, 21, 64'hcafebabe);
      for (int k = 0; k < 10; k++) begin
         drive(2'b11, 25, 26, 64'h5555, 64'h6666, 21, 25);
         expect_val("mid_ready", SRC_RDY_B, 0, 64'h0);
         tick();
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int k = 0; k < 34; k++) begin
         if (k < D) drive(2'b11, 25, 26, 64'h5555, 64'h6666, 21, 25);
         else       drive(2'b00, 25, 26, 64'h0, 64'h0, 25, 26);
         expect_val("resweep_ready_b", SRC_RDY_B, 0, (k >= D) ? 64'h1 : 64'h0);
         expect_val("resweep_ready_n", SRC_RDY_N, 0, (k >= D) ? 64'h1 : 64'h0);
         if (k == 5) begin
            expect_val("init_rd_nobyp", SRC_RD_B, 1, 64'h0);
            expect_val("init_rd_held",  SRC_RD_B, 0, 64'h0);
         end
         if (k == 21) expect_val("resweep_dbg21_pre", SRC_DBG_B, 21, 64'hcafebabe);
         if (k == 22) begin
            expect_val("resweep_dbg21_b", SRC_DBG_B, 21, 64'h0);
            expect_val("resweep_dbg21_n", SRC_DBG_N, 21, 64'h0);
         end
         tick();
      end
      expect_all_zero("resweep_clear");
      expect_val("resweep_rd25", SRC_RD_B, 0, 64'h0);
      expect_val("resweep_rd26", SRC_RD_N, 1, 64'h0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
